// File: rtl/tank_sprite_scheduler.sv
// Shares one sprite ROM between several tanks: during horizontal blanking each visible
// tank's next-line row is fetched into a per-tank line buffer, then composited on display.
module tank_sprite_scheduler #(
   parameter int NUM_TANKS = 4,
   parameter int SPR       = 32
) (
   input  logic                    vga_clk,
   input  logic                    reset_n,
   input  logic [9:0]              DrawX,
   input  logic [9:0]              DrawY,
   input  logic [NUM_TANKS*10-1:0] tank_x,
   input  logic [NUM_TANKS*10-1:0] tank_y,
   input  logic [NUM_TANKS*2-1:0]  tank_dir,
   input  logic [NUM_TANKS-1:0]    tank_en,
   output logic [9:0]              rom_address,
   input  logic [3:0]              rom_q,
   output logic [3:0]              pix_index,
   output logic                    pix_hit,
   output logic                    busy
);

   localparam int CW = $clog2(SPR);
   localparam int TW = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
   localparam logic [9:0]    SPR10     = 10'(SPR);
   localparam logic [CW-1:0] COL_LAST  = CW'(SPR - 1);
   localparam logic [TW-1:0] TANK_LAST = TW'(NUM_TANKS - 1);

   typedef enum logic [1:0] {IDLE, SELECT, FETCH, DRAIN} state_t;
   state_t state, state_next;

   logic [9:0]           lat_x   [NUM_TANKS];
   logic [9:0]           lat_y   [NUM_TANKS];
   logic [1:0]           lat_dir [NUM_TANKS];
   logic [NUM_TANKS-1:0] lat_en;
   logic [NUM_TANKS-1:0] line_valid;
   logic [3:0]           line_buf [NUM_TANKS][SPR];

   logic [TW-1:0] tank_cnt;
   logic [CW-1:0] col, wr_col, row;
   logic          wr_pending;
   logic [9:0]    target_y, addr_hold, fetch_addr, sel_r, disp_k;
   logic          sel_match, last_tank, start, abort;
   logic [3:0]    disp_idx;

   assign start       = (state == IDLE) && (DrawX == 10'd640);
   assign abort       = (state != IDLE) && (DrawX == 10'd0);
   assign last_tank   = (tank_cnt == TANK_LAST);
   assign sel_r       = target_y - lat_y[tank_cnt];
   assign sel_match   = lat_en[tank_cnt] && (sel_r < SPR10);
   assign busy        = (state != IDLE);
   assign rom_address = (state == FETCH) ? fetch_addr : addr_hold;

   // Orientation is applied purely by permuting/inverting the row and column address bits.
   always_comb begin
      fetch_addr = '0;
      case (lat_dir[tank_cnt])
         2'd0:    fetch_addr = 10'({row, col});
         2'd1:    fetch_addr = 10'({~row, col});
         2'd2:    fetch_addr = 10'({col, row});
         default: fetch_addr = 10'({~col, ~row});
      endcase
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SELECT;
         SELECT:  if (sel_match) state_next = FETCH;
                  else if (last_tank) state_next = IDLE;
         FETCH:   if (col == COL_LAST) state_next = DRAIN;
         DRAIN:   state_next = last_tank ? IDLE : SELECT;
         default: state_next = IDLE;
      endcase
      if (abort) state_next = IDLE;
   end

   // ROM data lags the address by one cycle, so each word is written one cycle after issue.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         tank_cnt   <= '0;
         col        <= '0;
         wr_col     <= '0;
         row        <= '0;
         wr_pending <= 1'b0;
         target_y   <= '0;
         addr_hold  <= '0;
         line_valid <= '0;
         lat_en     <= '0;
         for (int i = 0; i < NUM_TANKS; i++) begin
            lat_x[i]   <= '0;
            lat_y[i]   <= '0;
            lat_dir[i] <= '0;
         end
      end else begin
         wr_pending <= (state == FETCH) && !abort;
         wr_col     <= col;
         if (abort) begin
            for (int i = 0; i < NUM_TANKS; i++)
               if (i >= int'(tank_cnt)) line_valid[i] <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  tank_cnt <= '0;
                  target_y <= (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
                  lat_en   <= tank_en;
                  for (int i = 0; i < NUM_TANKS; i++) begin
                     lat_x[i]   <= tank_x[10*i +: 10];
                     lat_y[i]   <= tank_y[10*i +: 10];
                     lat_dir[i] <= tank_dir[2*i +: 2];
                  end
               end
               SELECT: begin
                  line_valid[tank_cnt] <= 1'b0;
                  row <= sel_r[CW-1:0];
                  col <= '0;
                  if (!sel_match && !last_tank) tank_cnt <= tank_cnt + 1'b1;
               end
               FETCH: begin
                  addr_hold <= fetch_addr;
                  col       <= col + 1'b1;
               end
               DRAIN: begin
                  line_valid[tank_cnt] <= 1'b1;
                  if (!last_tank) tank_cnt <= tank_cnt + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge vga_clk) begin
      if (wr_pending) line_buf[tank_cnt][wr_col] <= rom_q;
   end

   // Walk from the highest tank down so the lowest-numbered opaque tank wins.
   always_comb begin
      disp_idx = '0;
      disp_k   = '0;
      for (int i = NUM_TANKS - 1; i >= 0; i--) begin
         disp_k = DrawX - lat_x[i];
         if (line_valid[i] && (disp_k < SPR10) && (line_buf[i][disp_k[CW-1:0]] != 4'd0))
            disp_idx = line_buf[i][disp_k[CW-1:0]];
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_index <= '0;
         pix_hit   <= 1'b0;
      end else if ((DrawX < 10'd640) && (DrawY < 10'd480)) begin
         pix_index <= disp_idx;
         pix_hit   <= (disp_idx != 4'd0);
      end else begin
         pix_index <= '0;
         pix_hit   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tank_sprite_scheduler.sv
// Directed bench for tank_sprite_scheduler: fetch addressing, compositing, abort and reset.
module tb_tank_sprite_scheduler;

   logic        vga_clk = 1'b0;
   logic        reset_n;
   logic [9:0]  DrawX, DrawY;
   logic [39:0] tank_x, tank_y;
   logic [7:0]  tank_dir;
   logic [3:0]  tank_en;
   logic [9:0]  rom_address;
   logic [3:0]  rom_q;
   logic [3:0]  pix_index;
   logic        pix_hit;
   logic        busy;

   logic [3:0] rom_mem [1024];
   int total = 0;
   int bad   = 0;
   int n;

   always #5 vga_clk = ~vga_clk;

   // Synchronous ROM: data for an address appears one cycle after it is presented.
   always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

   tank_sprite_scheduler #(.NUM_TANKS(4), .SPR(32)) dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
      .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir), .tank_en(tank_en),
      .rom_address(rom_address), .rom_q(rom_q), .pix_index(pix_index),
      .pix_hit(pix_hit), .busy(busy)
   );

   task automatic step(input int cycles);
      repeat (cycles) begin
         @(posedge vga_clk);
         #1;
      end
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input int i, input int x, input int y, input int dir, input int en);
      tank_x[10*i +: 10] = 10'(x);
      tank_y[10*i +: 10] = 10'(y);
      tank_dir[2*i +: 2] = 2'(dir);
      tank_en[i]         = en[0];
   endtask

   task automatic start_fetch(input int line);
      DrawY = 10'(line);
      DrawX = 10'd640;
      step(1);
      DrawX = 10'd641;
      check_output("start_busy", busy, 1);
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 300) begin
         cycles++;
         step(1);
      end
   endtask

   // Leaves SELECT for a matching tank 0, then checks all 32 issued addresses.
   task automatic fetch_addrs(input string tag, input int dir, input int r);
      int exp;
      step(1);
      for (int c = 0; c < 32; c++) begin
         case (dir)
            0:       exp = r * 32 + c;
            1:       exp = (31 - r) * 32 + c;
            2:       exp = c * 32 + r;
            default: exp = (31 - c) * 32 + (31 - r);
         endcase
         check_output($sformatf("%s_addr_c%0d", tag, c), rom_address, exp);
         step(1);
      end
   endtask

   task automatic pixel(input int x, input int y, input int exp);
      DrawX = 10'(x);
      DrawY = 10'(y);
      step(1);
      check_output($sformatf("pix_index_x%0d_y%0d", x, y), pix_index, exp);
      check_output($sformatf("pix_hit_x%0d_y%0d", x, y), pix_hit, (exp != 0));
      DrawX = 10'd641;
   endtask

   initial begin
      for (int a = 0; a < 1024; a++) rom_mem[a] = 4'((a % 15) + 1);
      rom_mem[3] = 4'd0;
      reset_n  = 1'b0;
      DrawX    = '0;
      DrawY    = '0;
      tank_x   = '0;
      tank_y   = '0;
      tank_dir = '0;
      tank_en  = '0;
      step(3);
      check_output("rst_busy", busy, 0);
      check_output("rst_rom_address", rom_address, 0);
      check_output("rst_pix_index", pix_index, 0);
      check_output("rst_pix_hit", pix_hit, 0);
      reset_n = 1'b1;
      step(2);

      $display("[TB] single tank, dir up");
      apply_stimulus(0, 100, 50, 0, 1);
      pixel(110, 50, 0);
      start_fetch(49);
      fetch_addrs("up", 0, 0);
      wait_idle(n);
      check_output("up_tail_cycles", n, 4);
      check_output("idle_addr_hold", rom_address, 31);
      for (int x = 99; x <= 132; x++)
         pixel(x, 50, (x >= 100 && x <= 131) ? int'(rom_mem[x - 100]) : 0);
      pixel(110, 480, 0);

      $display("[TB] dir right r=0, dir left r=5");
      apply_stimulus(0, 100, 50, 3, 1);
      start_fetch(49);
      fetch_addrs("right", 3, 0);
      wait_idle(n);
      apply_stimulus(0, 100, 45, 2, 1);
      start_fetch(49);
      fetch_addrs("left", 2, 5);
      wait_idle(n);

      $display("[TB] overlapping tanks 0 and 1");
      apply_stimulus(0, 200, 50, 0, 1);
      apply_stimulus(1, 200, 50, 1, 1);
      start_fetch(49);
      wait_idle(n);
      check_output("overlap_busy_cycles", n, 70);
      for (int c = 0; c < 32; c++)
         pixel(200 + c, 50, (rom_mem[c] != 0) ? int'(rom_mem[c]) : int'(rom_mem[992 + c]));

      $display("[TB] all four tanks matching");
      apply_stimulus(2, 400, 50, 2, 1);
      apply_stimulus(3, 500, 50, 3, 1);
      start_fetch(49);
      wait_idle(n);
      check_output("all4_busy_cycles", n, 136);
      pixel(400, 50, rom_mem[0]);

      $display("[TB] abort on DrawX==0");
      start_fetch(49);
      step(5);
      DrawX = 10'd0;
      step(1);
      check_output("abort_busy", busy, 0);
      DrawX = 10'd641;
      pixel(205, 50, 0);
      pixel(405, 50, 0);

      $display("[TB] target wrap at DrawY 524 and latched x");
      apply_stimulus(1, 0, 0, 0, 0);
      apply_stimulus(2, 0, 0, 0, 0);
      apply_stimulus(3, 0, 0, 0, 0);
      apply_stimulus(0, 300, 1000, 0, 1);
      start_fetch(524);
      fetch_addrs("wrap", 0, 24);
      wait_idle(n);
      apply_stimulus(0, 50, 1000, 0, 1);
      pixel(300, 0, rom_mem[768]);
      pixel(305, 0, rom_mem[773]);
      pixel(50, 0, 0);

      apply_stimulus(0, 300, 510, 0, 1);
      start_fetch(523);
      step(1);
      check_output("r14_first_addr", rom_address, 448);
      wait_idle(n);
      check_output("r14_tail_cycles", n, 36);

      $display("[TB] reset during fetch");
      apply_stimulus(0, 100, 50, 0, 1);
      start_fetch(49);
      step(11);
      check_output("mid_fetch_addr_c10", rom_address, 10);
      reset_n = 1'b0;
      #1;
      check_output("async_rst_busy", busy, 0);
      check_output("async_rst_addr", rom_address, 0);
      step(1);
      reset_n = 1'b1;
      step(1);
      pixel(110, 50, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
